// File: rtl/rate_mon_pkg.sv
// Shared types for the multi-rate monitor: store/dump FSM encodings and word-to-byte sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rate_mon_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WR
    } store_state_t;

    typedef enum logic [2:0] {
        D_WAIT,
        D_HDR_HI,
        D_HDR_LO,
        D_DATA,
        D_NEXT,
        D_DONE
    } dump_state_t;

    // Number of UART bytes needed to carry one counter word.
    function automatic int bytes_per_word(input int cw);
        return (cw + 7) / 8;
    endfunction

endpackage

// File: rtl/rate_mon_ram.sv
// Record store: simple dual-port RAM, write port A, registered read port B.
// Latency: one clock from read address to read data; a same-address write is returned on that read.
// Backpressure: none; accepts a write and a read every clock.
module rate_mon_ram #(
    parameter int DW = 24,
    parameter int AW = 11
) (
    input  logic          Clock,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    // Port A write.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Port B registered read; a colliding write is seen immediately (write-first).
    always_ff @(posedge Clock) begin
        if (we && (wa == ra)) begin
            rd <= wd;
        end else begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/multi_rate_monitor.sv
// Counts per-channel hits over fixed intervals, logs one record per interval to RAM, dumps the log over a UART.
// Latency: a record lands in RAM NCH clocks after the interval strobe; dump bytes are paced by the UART handshake.
// Backpressure: TxD_Busy stalls the dump byte by byte; snapshots arriving mid-dump are discarded.
module multi_rate_monitor
    import rate_mon_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int CW        = 24,
    parameter int AW        = 11,
    parameter int INTERVAL  = 10000000,
    parameter int SPILL_THR = 10
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           RunInProg,
    input  logic [NCH-1:0] Hit,
    input  logic           DmpStart,
    input  logic           TxD_Busy,
    output logic           TxD_Start,
    output logic [7:0]     TxD_Data,
    output logic           DmpDone,
    output logic           SpillFlag,
    output logic           Overflow
);

    localparam int TW    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int PW    = AW + 1;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BPW   = bytes_per_word(CW);
    localparam int DEPTH = 2 ** AW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [TW-1:0]  timer;
    logic           snap;
    logic [CW-1:0]  cnt    [NCH];
    logic [CW-1:0]  shadow [NCH];

    store_state_t   st_state, st_next;
    logic [CHW-1:0] wr_ch, wr_ch_nxt;
    logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
    logic           ovf_nxt;
    logic           ram_we;
    logic           room;

    dump_state_t    d_state, d_next;
    logic           dump_active;
    logic           dump_go;
    logic           dmp_req, dmp_req_nxt;
    logic [PW-1:0]  rd_idx, rd_idx_nxt;
    logic [1:0]     byte_idx, byte_idx_nxt;
    logic           tx_start_nxt;
    logic [7:0]     tx_data_nxt;
    logic [CW-1:0]  rd_data;
    logic [7:0]     cur_byte;
    logic [15:0]    hdr;
    logic           sending;
    logic           byte_done;

    // Picks byte idx (0 = least significant) of a word, zero-padding above CW.
    function automatic logic [7:0] word_byte(input logic [CW-1:0] w, input logic [1:0] idx);
        logic [8*BPW-1:0] pad;
        pad = (8*BPW)'(w);
        return pad[8*idx +: 8];
    endfunction

    // The strobe fires on the last clock of each interval; that clock's hits belong to the next interval.
    assign snap = RunInProg && (timer == TW'(INTERVAL - 1));

    // Interval timer, frozen while the run is paused.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            timer <= '0;
        end else if (RunInProg) begin
            timer <= snap ? '0 : timer + TW'(1);
        end
    end

    // Saturating hit counters; on the strobe they hand off to shadows and restart, keeping a same-cycle hit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
            SpillFlag <= 1'b0;
        end else if (RunInProg) begin
            for (int i = 0; i < NCH; i++) begin
                if (snap) begin
                    shadow[i] <= cnt[i];
                    cnt[i]    <= CW'(Hit[i]);
                end else if (Hit[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            if (snap) begin
                SpillFlag <= (cnt[0] > CW'(SPILL_THR));
            end
        end
    end

    assign dump_active = (d_state != D_WAIT);
    assign room        = ((PW'(DEPTH) - wr_ptr) >= PW'(NCH));

    // Store FSM registers: state, channel index, write pointer and sticky drop flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            st_state <= ST_IDLE;
            wr_ch    <= '0;
            wr_ptr   <= '0;
            Overflow <= 1'b0;
        end else begin
            st_state <= st_next;
            wr_ch    <= wr_ch_nxt;
            wr_ptr   <= wr_ptr_nxt;
            Overflow <= ovf_nxt;
        end
    end

    // Store FSM next state: whole record or nothing; a finished dump empties the log.
    always_comb begin
        st_next    = st_state;
        wr_ch_nxt  = wr_ch;
        wr_ptr_nxt = wr_ptr;
        ovf_nxt    = Overflow;
        ram_we     = 1'b0;
        case (st_state)
            ST_IDLE: begin
                if (snap && !dump_active) begin
                    if (room) begin
                        st_next   = ST_WR;
                        wr_ch_nxt = '0;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
            end
            ST_WR: begin
                ram_we     = 1'b1;
                wr_ptr_nxt = wr_ptr + PW'(1);
                if (wr_ch == CHW'(NCH - 1)) begin
                    st_next = ST_IDLE;
                end else begin
                    wr_ch_nxt = wr_ch + CHW'(1);
                end
            end
            default: st_next = ST_IDLE;
        endcase
        if (d_state == D_DONE) begin
            wr_ptr_nxt = '0;
            ovf_nxt    = 1'b0;
        end
    end

    rate_mon_ram #(
        .DW(CW),
        .AW(AW)
    ) u_ram (
        .Clock (Clock),
        .we    (ram_we),
        .wa    (wr_ptr[AW-1:0]),
        .wd    (shadow[wr_ch]),
        .ra    (rd_idx[AW-1:0]),
        .rd    (rd_data)
    );

    assign hdr       = 16'(wr_ptr);
    assign sending   = (d_state == D_HDR_HI) || (d_state == D_HDR_LO) || (d_state == D_DATA);
    assign byte_done = TxD_Start && TxD_Busy;
    assign DmpDone   = (d_state == D_DONE);
    // A dump waits out any pending snapshot/store so that record is counted in the header.
    assign dump_go   = (DmpStart || dmp_req) && (st_state == ST_IDLE) && !snap;

    // Byte offered to the UART in the current dump state.
    always_comb begin
        case (d_state)
            D_HDR_HI: cur_byte = hdr[15:8];
            D_HDR_LO: cur_byte = hdr[7:0];
            default:  cur_byte = word_byte(rd_data, byte_idx);
        endcase
    end

    // Dump FSM registers, including the registered UART request and data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            d_state   <= D_WAIT;
            dmp_req   <= 1'b0;
            rd_idx    <= '0;
            byte_idx  <= '0;
            TxD_Start <= 1'b0;
            TxD_Data  <= '0;
        end else begin
            d_state   <= d_next;
            dmp_req   <= dmp_req_nxt;
            rd_idx    <= rd_idx_nxt;
            byte_idx  <= byte_idx_nxt;
            TxD_Start <= tx_start_nxt;
            TxD_Data  <= tx_data_nxt;
        end
    end

    // Dump FSM next state: header then words MSB first; the read address moves one clock ahead of each word.
    always_comb begin
        d_next       = d_state;
        dmp_req_nxt  = dmp_req;
        rd_idx_nxt   = rd_idx;
        byte_idx_nxt = byte_idx;
        tx_start_nxt = TxD_Start;
        tx_data_nxt  = TxD_Data;
        if (sending) begin
            if (!TxD_Start && !TxD_Busy) begin
                tx_start_nxt = 1'b1;
                tx_data_nxt  = cur_byte;
            end else if (byte_done) begin
                tx_start_nxt = 1'b0;
            end
        end
        case (d_state)
            D_WAIT: begin
                if (dump_go) begin
                    dmp_req_nxt = 1'b0;
                    if (wr_ptr != '0) begin
                        d_next       = D_HDR_HI;
                        rd_idx_nxt   = '0;
                        byte_idx_nxt = 2'(BPW - 1);
                    end
                end else if (DmpStart) begin
                    dmp_req_nxt = 1'b1;
                end
            end
            D_HDR_HI: if (byte_done) d_next = D_HDR_LO;
            D_HDR_LO: if (byte_done) d_next = D_DATA;
            D_DATA: begin
                if (byte_done) begin
                    if (byte_idx == 2'd0) begin
                        d_next     = D_NEXT;
                        rd_idx_nxt = rd_idx + PW'(1);
                    end else begin
                        byte_idx_nxt = byte_idx - 2'd1;
                    end
                end
            end
            D_NEXT: begin
                byte_idx_nxt = 2'(BPW - 1);
                d_next       = (rd_idx == wr_ptr) ? D_DONE : D_DATA;
            end
            D_DONE:  d_next = D_WAIT;
            default: d_next = D_WAIT;
        endcase
    end

endmodule

// File: tb/tb_multi_rate_monitor.sv
// Directed bench for multi_rate_monitor: a 24-bit/8-deep instance and an 8-bit saturation instance share a UART model.
// Latency: n/a.
// Backpressure: the UART model holds TxD_Busy high for busy_len clocks per accepted byte.
module tb_multi_rate_monitor;

    localparam int INTV   = 100;
    localparam int S_INTV = 400;

    logic       clock = 1'b0;
    logic       reset, run, dmp_start, tx_busy;
    logic [1:0] hit;
    logic       tx_start, dmp_done, spill, ovf;
    logic [7:0] tx_data;
    logic       s_run, s_dmp_start;
    logic [1:0] s_hit;
    logic       s_tx_start, s_dmp_done, s_spill, s_ovf;
    logic [7:0] s_tx_data;

    int checks = 0;
    int errors = 0;
    int busy_len = 2;
    int done_cnt = 0;
    int s_done_cnt = 0;
    int proto_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    multi_rate_monitor #(.NCH(2), .CW(24), .AW(3), .INTERVAL(INTV), .SPILL_THR(10)) u_dut (
        .Clock(clock), .Reset(reset), .RunInProg(run), .Hit(hit), .DmpStart(dmp_start),
        .TxD_Busy(tx_busy), .TxD_Start(tx_start), .TxD_Data(tx_data), .DmpDone(dmp_done),
        .SpillFlag(spill), .Overflow(ovf)
    );

    multi_rate_monitor #(.NCH(2), .CW(8), .AW(3), .INTERVAL(S_INTV), .SPILL_THR(10)) u_sat (
        .Clock(clock), .Reset(reset), .RunInProg(s_run), .Hit(s_hit), .DmpStart(s_dmp_start),
        .TxD_Busy(tx_busy), .TxD_Start(s_tx_start), .TxD_Data(s_tx_data), .DmpDone(s_dmp_done),
        .SpillFlag(s_spill), .Overflow(s_ovf)
    );

    initial forever #5 clock = ~clock;

    // UART model: accepts a byte on each rising request, then stays busy for busy_len clocks.
    initial begin
        logic st, prev_st;
        logic [7:0] dt, prev_dt;
        int busy_cnt;
        tx_busy = 1'b0; prev_st = 1'b0; prev_dt = '0; busy_cnt = 0;
        forever begin
            @(negedge clock);
            st = tx_start | s_tx_start;
            dt = tx_start ? tx_data : s_tx_data;
            if (st && !prev_st && tx_busy) proto_err++;
            if (st && prev_st && (dt !== prev_dt)) proto_err++;
            if (st && !prev_st) begin
                rx_q.push_back(dt);
                tx_busy = 1'b1;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            prev_st = st;
            prev_dt = dt;
            if (dmp_done) done_cnt++;
            if (s_dmp_done) s_done_cnt++;
        end
    end

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; hit = '0; dmp_start = 1'b0;
        s_run = 1'b0; s_hit = '0; s_dmp_start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    // One interval on the main instance; optional Hit[0] and DmpStart on the strobe cycle.
    task automatic run_interval(input int h0, input int h1, input bit hit_last, input bit dmp_last);
        run = 1'b1;
        for (int c = 0; c < INTV; c++) begin
            hit[0]    = (c < h0) || (hit_last && (c == INTV - 1));
            hit[1]    = (c < h1);
            dmp_start = dmp_last && (c == INTV - 1);
            @(posedge clock); #1;
        end
        hit = '0;
        dmp_start = 1'b0;
    endtask

    // Waits (bounded) for the selected instance to finish a dump; pulses DmpStart unless one is already pending.
    task automatic run_dump(input bit use_s, input bit pulse, input int limit, output bit ok);
        int d0;
        ok = 1'b0;
        d0 = use_s ? s_done_cnt : done_cnt;
        if (pulse) begin
            if (use_s) s_dmp_start = 1'b1; else dmp_start = 1'b1;
            @(posedge clock); #1;
            s_dmp_start = 1'b0; dmp_start = 1'b0;
        end
        for (int n = 0; n < limit; n++) begin
            if ((use_s ? s_done_cnt : done_cnt) != d0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic add_word(input int w, input int nb);
        for (int b = nb - 1; b >= 0; b--) exp_q.push_back(8'((w >> (8 * b)) & 255));
    endtask

    task automatic test_reset();
        int d0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_txstart got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_txdata got %h want 00", tx_data); end
        checks++; if (dmp_done !== 1'b0) begin errors++; $display("FAIL rst_dmpdone got %b want 0", dmp_done); end
        checks++; if (spill !== 1'b0) begin errors++; $display("FAIL rst_spill got %b want 0", spill); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", ovf); end
        do_reset();
        // Empty log: the request must be ignored.
        rx_q.delete(); d0 = done_cnt;
        dmp_start = 1'b1; @(posedge clock); #1 dmp_start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL empty_dump_bytes got %0d want 0", rx_q.size()); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL empty_dump_done got %0d want %0d", done_cnt, d0); end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        run_interval(7, 3, 0, 0);
        run = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (spill !== 1'b0) begin errors++; $display("FAIL basic_spill got %b want 0", spill); end
        rx_q.delete(); exp_q.delete();
        add_word(2, 2); add_word(7, 3); add_word(3, 3);
        run_dump(0, 1, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done got timeout want DmpDone"); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_spill();
        do_reset();
        run_interval(11, 0, 0, 0);
        checks++; if (spill !== 1'b1) begin errors++; $display("FAIL spill_11 got %b want 1", spill); end
        run_interval(10, 0, 0, 0);
        run = 1'b0;
        checks++; if (spill !== 1'b0) begin errors++; $display("FAIL spill_10 got %b want 0", spill); end
    endtask

    task automatic test_snap_hit();
        bit ok;
        do_reset();
        run_interval(5, 0, 1, 0);   // 5 counted, strobe-cycle hit carries over
        run_interval(4, 0, 0, 0);   // carried 1 + 4
        run_interval(2, 0, 0, 0);
        run = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        rx_q.delete(); exp_q.delete();
        add_word(6, 2);
        add_word(5, 3); add_word(0, 3); add_word(5, 3); add_word(0, 3); add_word(2, 3); add_word(0, 3);
        run_dump(0, 1, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL snaphit_done got timeout want DmpDone"); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL snaphit_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL snaphit_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        do_reset();
        rx_q.delete(); exp_q.delete();
        add_word(2, 2); add_word(6, 3); add_word(1, 3);
        run_interval(6, 1, 0, 1);
        run = 1'b0;
        run_dump(0, 0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL same_done got timeout want DmpDone"); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL same_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL same_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int h0 [5] = '{1, 2, 3, 4, 12};
        int h1 [5] = '{0, 2, 4, 6, 8};
        int d0;
        do_reset();
        for (int k = 0; k < 5; k++) run_interval(h0[k], h1[k], 0, 0);
        run = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
        checks++; if (spill !== 1'b1) begin errors++; $display("FAIL ovf_spill_on_drop got %b want 1", spill); end
        rx_q.delete(); exp_q.delete();
        add_word(8, 2);
        for (int k = 0; k < 4; k++) begin add_word(h0[k], 3); add_word(h1[k], 3); end
        d0 = done_cnt;
        run_dump(0, 1, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_done got timeout want DmpDone"); end
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL ovf_done_pulses got %0d want 1", done_cnt - d0); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_busy_stretch();
        bit ok;
        do_reset();
        busy_len = 50;
        proto_err = 0;
        run_interval(9, 12, 0, 0);
        run = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        rx_q.delete(); exp_q.delete();
        add_word(2, 2); add_word(9, 3); add_word(12, 3);
        run_dump(0, 1, 3000, ok);
        busy_len = 2;
        repeat (60) @(posedge clock);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL busy_done got timeout want DmpDone"); end
        checks++; if (proto_err != 0) begin errors++; $display("FAIL busy_handshake got %0d violations want 0", proto_err); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_saturate();
        bit ok;
        do_reset();
        s_run = 1'b1;
        for (int c = 0; c < S_INTV; c++) begin
            s_hit[0] = (c < 300);
            s_hit[1] = (c < 254);
            @(posedge clock); #1;
        end
        s_hit = '0; s_run = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (s_spill !== 1'b1) begin errors++; $display("FAIL sat_spill got %b want 1", s_spill); end
        rx_q.delete(); exp_q.delete();
        add_word(2, 2); add_word(255, 1); add_word(254, 1);
        run_dump(1, 1, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_done got timeout want DmpDone"); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_dump();
        int d0;
        do_reset();
        run_interval(3, 4, 0, 0);
        run = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        busy_len = 4;
        rx_q.delete(); d0 = done_cnt;
        dmp_start = 1'b1; @(posedge clock); #1 dmp_start = 1'b0;
        for (int n = 0; n < 500 && rx_q.size() < 5; n++) @(negedge clock);
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL midrst_reach got %0d bytes want 5", rx_q.size()); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_txstart got %b want 0", tx_start); end
        @(posedge clock); #1 reset = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL midrst_extra got %0d bytes want 5", rx_q.size()); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL midrst_done got %0d pulses want 0", done_cnt - d0); end
        // Pointer cleared: a new request finds an empty log.
        dmp_start = 1'b1; @(posedge clock); #1 dmp_start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL midrst_ptr got %0d bytes want 5", rx_q.size()); end
        busy_len = 2;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; hit = '0; dmp_start = 1'b0;
        s_run = 1'b0; s_hit = '0; s_dmp_start = 1'b0;
        test_reset();
        test_basic();
        test_spill();
        test_snap_hit();
        test_same_cycle();
        test_overflow();
        test_busy_stretch();
        test_saturate();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_rate_monitor.md
MULTI_RATE_MONITOR -- requirements
Module: multi_rate_monitor

Interface
REQ-001 Parameter NCH, default 2: number of counted channels, 1..4.
REQ-002 Parameter CW, default 24: per-channel counter width, 8..32.
REQ-003 Parameter AW, default 11: RAM address width (2**AW words).
REQ-004 Parameter INTERVAL, default 10000000: clocks per sample interval (0.1 s at 100 MHz).
REQ-005 Parameter SPILL_THR, default 10: channel-0 count above which SpillFlag sets.
REQ-006 Clock  input  1  system clock; all logic on rising edge.
REQ-007 Reset  input  1  synchronous, active-high.
REQ-008 RunInProg  input  1  counting and timing enabled while high.
REQ-009 Hit  input  NCH  one-clock pulse per event per channel (bit 0 = trigger, bit 1 = accepted event).
REQ-010 DmpStart  input  1  request to dump stored records to UART.
REQ-011 TxD_Busy  input  1  UART busy; cannot accept a byte.
REQ-012 TxD_Start  output  1  byte on TxD_Data valid, request to send.
REQ-013 TxD_Data  output  8  byte to UART.
REQ-014 DmpDone  output  1  one-clock pulse when dump completes.
REQ-015 SpillFlag  output  1  last channel-0 sample > SPILL_THR.
REQ-016 Overflow  output  1  sticky: a record was dropped because RAM was full.

Function
REQ-017 Interval timer SHALL increment each clock while RunInProg; at INTERVAL-1 it SHALL wrap to 0 and raise a one-clock snapshot strobe.
REQ-018 Per-channel counters SHALL saturate at 2**CW-1, never wrap.
REQ-019 On snapshot, all counters SHALL copy into shadow registers and restart at 0, or at 1 if Hit bit high that cycle; no hit lost.
REQ-020 Store FSM states IDLE, WR(ch 0..NCH-1): after snapshot, write NCH shadow words to consecutive addresses, one per clock, channel 0 first.
REQ-021 If fewer than NCH free words remain, the whole record SHALL be dropped and Overflow set; no partial records.
REQ-022 SpillFlag SHALL update on each snapshot to (channel-0 shadow > SPILL_THR), even if record dropped.
REQ-023 Writes SHALL be inhibited while a dump is active; snapshots during dump are discarded without setting Overflow.
REQ-024 Dump FSM states WAIT, HDR_HI, HDR_LO, DATA, NEXT, DONE; DmpStart in WAIT with write pointer > 0 starts dump, else ignored.
REQ-025 Header SHALL be 16-bit stored word count, MSB first, zero-extended.
REQ-026 Each word SHALL be sent as ceil(CW/8) bytes, most-significant first, zero-padded in the top byte.
REQ-027 Byte handshake: TxD_Start asserted only when TxD_Busy low; held with stable TxD_Data until TxD_Busy seen high, then deasserted; next byte waits for TxD_Busy low.
REQ-028 RAM read latency one clock; read issued at least one clock before first byte of a word.
REQ-029 After last byte, DONE SHALL pulse DmpDone, clear write pointer and Overflow, return to WAIT.
REQ-030 Snapshot and DmpStart in same cycle: snapshot record SHALL be stored before dump begins and included in count.

Reset
REQ-031 Reset SHALL zero timer, counters, shadows, pointers; store FSM IDLE, dump FSM WAIT.
REQ-032 Reset values: TxD_Start 0, TxD_Data 0, DmpDone 0, SpillFlag 0, Overflow 0; RAM contents undefined.
REQ-033 Reset mid-dump SHALL abort immediately; no further TxD_Start.

Structure
REQ-034 Package rate_mon_pkg SHALL hold state encodings and the bytes-per-word function.
REQ-035 Sub-module rate_mon_ram: simple dual-port RAM, CW wide, 2**AW deep, write-first port A, registered read port B.

Verification
REQ-036 INTERVAL=100, NCH=2, 7 Hit[0] and 3 Hit[1] pulses in interval -> RAM words 7, 3; SpillFlag 0.
REQ-037 Hit[0] on snapshot cycle -> next interval count starts at 1; totals over 3 intervals equal pulses applied.
REQ-038 CW=8, 300 Hit[0] pulses in one interval -> stored 255.
REQ-039 AW=3, NCH=2, 5 intervals -> 4 records stored (8 words), Overflow 1; dump sends header 0x00 0x08 then 8 words x 3 bytes; DmpDone pulse; Overflow 0 after.
REQ-040 TxD_Busy held high 50 clocks per byte -> every byte sent once, in order, TxD_Data stable while TxD_Start high.
REQ-041 Reset asserted during third data byte -> TxD_Start 0 next clock, DmpDone never pulses, pointer 0.
